// File: rtl/clksel_pkg.sv
// Shared types and default constants for the PHI2 clock-select sequencer.
package clksel_pkg;

  typedef enum logic [4:0] {
    LS_RUN  = 5'b00001,
    LS_HOLD = 5'b00010,
    TO_HS   = 5'b00100,
    HS_RUN  = 5'b01000,
    TO_LS   = 5'b10000
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_HOLD_CYCLES = 2;
  localparam int DEF_TIMEOUT     = 64;
  localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/clksel_seq_if.sv
// Bundle between the sequencer, the CPU decode/config side and the clock switch.
interface clksel_seq_if;
  logic host_req;
  logic force_ls;
  logic lsclk_in;
  logic hsclk_selected;
  logic lsclk_selected;
  logic err_clr;
  logic hsclk_sel;
  logic busy;
  logic cpu_hs;
  logic sel_err;

  modport master (
    output host_req, force_ls, lsclk_in, hsclk_selected, lsclk_selected, err_clr,
    input  hsclk_sel, busy, cpu_hs, sel_err
  );

  modport slave (
    input  host_req, force_ls, lsclk_in, hsclk_selected, lsclk_selected, err_clr,
    output hsclk_sel, busy, cpu_hs, sel_err
  );
endinterface

// File: rtl/clksel_seq_sync_ff.sv
// Multi-flop synchroniser bringing an asynchronous level into the hsclk_in domain.
module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic hsclk_in,
  input  logic rst_b,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) chain <= '0;
    else        chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/clksel_seq.sv
// Sequences HS/LS clock-switch requests from host-bus demand, with hold-off
// after host access and timeout detection on the switch handshake.
module clksel_seq
  import clksel_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input logic         hsclk_in,
  input logic         rst_b,
  clksel_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  logic hs_s, ls_s, lc_s, lc_d;
  logic ls_fall, want_ls;

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_hs_sync (
    .hsclk_in(hsclk_in), .rst_b(rst_b), .d(bus.hsclk_selected), .q(hs_s));
  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_ls_sync (
    .hsclk_in(hsclk_in), .rst_b(rst_b), .d(bus.lsclk_selected), .q(ls_s));
  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_lc_sync (
    .hsclk_in(hsclk_in), .rst_b(rst_b), .d(bus.lsclk_in), .q(lc_s));

  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) lc_d <= 1'b0;
    else        lc_d <= lc_s;
  end

  assign ls_fall = lc_d & ~lc_s;
  assign want_ls = bus.host_req | bus.force_ls;

  state_t           state, nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic [CNT_W-1:0] to_cnt, to_nxt;
  logic             err_set;
  logic             hsclk_sel_r, busy_r, cpu_hs_r, sel_err_r;

  always_comb begin
    nxt      = state;
    hold_nxt = hold_cnt;
    to_nxt   = to_cnt;
    err_set  = 1'b0;
    case (state)
      LS_RUN: begin
        if (!want_ls && ls_fall) begin
          nxt      = LS_HOLD;
          hold_nxt = CNT_W'(1);
        end
      end
      LS_HOLD: begin
        // Host demand always wins over a pending return to HS.
        if (want_ls) begin
          nxt      = LS_RUN;
          hold_nxt = '0;
        end else if (ls_fall) begin
          if (hold_cnt >= HOLD_LAST) begin
            nxt      = TO_HS;
            hold_nxt = '0;
            to_nxt   = '0;
          end else begin
            hold_nxt = sat_inc(hold_cnt);
          end
        end
      end
      TO_HS: begin
        to_nxt = sat_inc(to_cnt);
        if (hs_s && !ls_s) begin
          nxt    = HS_RUN;
          to_nxt = '0;
        end else if (want_ls) begin
          nxt    = TO_LS;
          to_nxt = '0;
        end else if (to_cnt == TO_LAST) begin
          err_set = 1'b1;
          nxt     = TO_LS;
          to_nxt  = '0;
        end
      end
      HS_RUN: begin
        if (!hs_s) begin
          err_set = 1'b1;
          nxt     = TO_LS;
          to_nxt  = '0;
        end else if (want_ls) begin
          nxt    = TO_LS;
          to_nxt = '0;
        end
      end
      TO_LS: begin
        // On timeout the request stays low; the switch is left to resolve it.
        if (ls_s && !hs_s) begin
          nxt    = LS_RUN;
          to_nxt = '0;
        end else if (to_cnt == TO_LAST) begin
          err_set = 1'b1;
        end else begin
          to_nxt = sat_inc(to_cnt);
        end
      end
      default: begin
        nxt      = LS_RUN;
        hold_nxt = '0;
        to_nxt   = '0;
      end
    endcase

    // Both clocks reported selected is a switch fault: drop to LS from anywhere.
    if (hs_s && ls_s) begin
      err_set  = 1'b1;
      hold_nxt = '0;
      if (state != TO_LS) begin
        nxt    = TO_LS;
        to_nxt = '0;
      end
    end
  end

  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      state       <= LS_RUN;
      hold_cnt    <= '0;
      to_cnt      <= '0;
      hsclk_sel_r <= 1'b0;
      busy_r      <= 1'b0;
      cpu_hs_r    <= 1'b0;
      sel_err_r   <= 1'b0;
    end else begin
      state       <= nxt;
      hold_cnt    <= hold_nxt;
      to_cnt      <= to_nxt;
      hsclk_sel_r <= (nxt == TO_HS) || (nxt == HS_RUN);
      busy_r      <= (nxt == TO_HS) || (nxt == TO_LS);
      cpu_hs_r    <= (nxt == HS_RUN);
      if (err_set)          sel_err_r <= 1'b1;
      else if (bus.err_clr) sel_err_r <= 1'b0;
    end
  end

  assign bus.hsclk_sel = hsclk_sel_r;
  assign bus.busy      = busy_r;
  assign bus.cpu_hs    = cpu_hs_r;
  assign bus.sel_err   = sel_err_r;

endmodule

// File: doc/clksel_seq.md
Name: clksel_seq

Overview:
Sequencer directly upstream of the PHI2 clock switch. It produces the switch's hsclk_sel request from CPU address-decode demands for host-bus access. It runs a handshake against the switch's hsclk_selected/lsclk_selected feedback. It holds the LS clock for a programmable number of host cycles after host access ends, and flags switch-over timeouts.

Parameters:
SYNC_STAGES, 2, flops in each feedback/host-clock synchroniser (min 2)
HOLD_CYCLES, 2, host-clock falling edges with no host demand required before returning to HS (min 1)
TIMEOUT, 64, hsclk_in cycles allowed for a switch-over handshake to complete
CNT_W, 8, counter width; must satisfy 2**CNT_W > max(TIMEOUT, HOLD_CYCLES)

Ports:
hsclk_in  in  1  high-speed clock; all state sampled on posedge
rst_b  in  1  asynchronous active-low reset
host_req  in  1  registered decode: current CPU access targets host bus/IO, hsclk_in-synchronous
force_ls  in  1  config: pin CPU to LS clock, hsclk_in-synchronous
lsclk_in  in  1  raw host clock, asynchronous
hsclk_selected  in  1  switch feedback, asynchronous
lsclk_selected  in  1  switch feedback, asynchronous
err_clr  in  1  single-cycle clear of sel_err
hsclk_sel  out  1  request to clock switch (1 = HS)
busy  out  1  switch-over in progress
cpu_hs  out  1  CPU confirmed running on HS clock
sel_err  out  1  sticky handshake-timeout flag

Behaviour:
- Reset is asynchronous, active-low; clock is hsclk_in. In reset: state LS_RUN, hsclk_sel=0, busy=0, cpu_hs=0, sel_err=0, counters 0, synchronisers 0. This matches the switch's own reset-to-LS.
- hsclk_selected, lsclk_selected and lsclk_in each pass through a SYNC_STAGES flop chain to give hs_s, ls_s and lc_s. One extra flop on lc_s gives lc_d. ls_fall = lc_d & !lc_s.
- want_ls = host_req | force_ls.
- All outputs are registered and decoded from next state; they change on the posedge the state changes.
- States and transitions:
  - LS_RUN: hsclk_sel=0. If !want_ls and ls_fall -> LS_HOLD with hold_cnt=1. Otherwise stay.
  - LS_HOLD: hsclk_sel=0. want_ls -> LS_RUN with hold_cnt=0; host demand always wins. Else on ls_fall: if hold_cnt==HOLD_CYCLES-1 -> TO_HS with to_cnt=0, else hold_cnt++.
  - TO_HS: hsclk_sel=1, busy=1, to_cnt++ each cycle.
    - hs_s & !ls_s -> HS_RUN.
    - Else want_ls -> TO_LS with to_cnt=0; abort is allowed, and the switch resolves it itself.
    - Else to_cnt==TIMEOUT-1 -> sel_err=1, TO_LS with to_cnt=0.
  - HS_RUN: hsclk_sel=1, cpu_hs=1. want_ls -> TO_LS with to_cnt=0. Latency is host_req high at posedge N -> hsclk_sel low after posedge N.
    - Unexpected !hs_s -> TO_LS and sel_err=1.
  - TO_LS: hsclk_sel=0, busy=1.
    - ls_s & !hs_s -> LS_RUN.
    - to_cnt==TIMEOUT-1 -> sel_err=1; stay in TO_LS with to_cnt saturated. The request is never re-raised.
- hsclk_sel is never raised while both hs_s and ls_s are 1. If both are seen in any state -> TO_LS and sel_err=1.
- sel_err is set by any timeout/fault and cleared by err_clr. Set wins if both occur in the same cycle.
- Counters saturate and never wrap.
- force_ls asserted in any state behaves as host_req held high.
- Reset mid-handshake returns to LS_RUN immediately. The switch's own reset handles glitch-free fallback.

Decomposition:
- Shared package clksel_pkg: state enum (LS_RUN, LS_HOLD, TO_HS, HS_RUN, TO_LS, one-hot 5-bit) and the default parameter constants.
- Sub-module sync_ff (SYNC_STAGES parameter, async rst_b), instantiated three times. Used for hsclk_selected, lsclk_selected and lsclk_in.

Test Plan:
1. Reset then idle, with hsclk 32 MHz, lsclk 2 MHz, switch model 3-cycle feedback, host_req=0: second ls_fall after reset -> hsclk_sel=1. Handshake completes -> cpu_hs=1, busy=0, sel_err=0.
2. In HS_RUN, pulse host_req high at posedge N: hsclk_sel=0 after posedge N, busy=1 until ls_s. host_req low for 2 ls_fall -> back to HS.
3. Drop host_req in LS, then re-assert after 1 ls_fall (HOLD_CYCLES=2): returns to LS_RUN, hsclk_sel stays 0, hold counter restarts.
4. TO_HS with the switch model stuck at hsclk_selected=0: after 64 cycles sel_err=1, hsclk_sel=0, state TO_LS then LS_RUN. err_clr -> sel_err=0.
5. force_ls=1 from reset: hsclk_sel stays 0 for 1000 lsclk cycles. Release -> HS after 2 ls_fall.
6. Assert rst_b low mid TO_HS: all outputs 0 asynchronously, state LS_RUN. Release -> normal sequence as in scenario 1.
